// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write sequencer: in-order update FIFO plus full-table flush sweep
module btb_update_ctrl #(
  parameter int ENTRIES = 2048,
  parameter int IDX_W   = 11,
  parameter int DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [31:0]      upd_target,
  output logic             upd_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             lookup_block,
  output logic             btb_wen,
  output logic [IDX_W-1:0] btb_index,
  output logic [31:0]      btb_wdat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] sweep_ctr;
  logic [IDX_W-1:0] idx_mem [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign upd_ready = (state == IDLE) && !full;
  // Index 0 is reserved, so such updates are acknowledged but never queued.
  assign enq = upd_valid && upd_ready && (upd_index != '0);
  assign deq = ((state == IDLE) || (state == DRAIN)) && !empty;

  assign flush_busy   = (state == DRAIN) || (state == SWEEP);
  assign lookup_block = (state == SWEEP);
  assign flush_done   = (state == DONE);

  always_comb begin
    btb_wen   = 1'b0;
    btb_index = '0;
    btb_wdat  = '0;
    if (state == SWEEP) begin
      btb_wen   = 1'b1;
      btb_index = sweep_ctr;
    end else if (deq) begin
      btb_wen   = 1'b1;
      btb_index = idx_mem[rd_ptr];
      btb_wdat  = tgt_mem[rd_ptr];
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      idx_mem[wr_ptr] <= upd_index;
      tgt_mem[wr_ptr] <= upd_target;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sweep_ctr <= IDX_W'(1);
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (flush_req) state <= DRAIN;
        end
        DRAIN: begin
          if (empty) state <= SWEEP;
        end
        SWEEP: begin
          // Stop at the last entry and rearm at 1 so entry 0 is never touched.
          if (sweep_ctr == IDX_W'(ENTRIES - 1)) begin
            state     <= DONE;
            sweep_ctr <= IDX_W'(1);
          end else begin
            sweep_ctr <= sweep_ctr + IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side sequencer for the branch target buffer (2048 entries, 32-bit targets, index 0 reserved/never written).
- Buffers resolved-branch updates from the execute/memory stage in a small in-order FIFO and issues at most one BTB write per cycle.
- Runs a flush sweep on request that zeroes every writable entry, stalling new updates and blocking fetch-side lookups until the sweep completes.

Parameters:
- ENTRIES, 2048, number of BTB entries; power of two.
- IDX_W, 11, index width, log2(ENTRIES).
- DEPTH, 4, pending-update FIFO depth; power of two, ≥2.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset.
- upd_valid  input  1  resolved branch update offered this cycle.
- upd_index  input  IDX_W  BTB index of the resolved branch.
- upd_target  input  32  resolved branch target.
- upd_ready  output  1  update accepted when upd_valid && upd_ready at rising edge.
- flush_req  input  1  level request to invalidate the whole BTB.
- flush_busy  output  1  high from flush acceptance through the final sweep write.
- flush_done  output  1  one-cycle pulse after the last sweep write.
- lookup_block  output  1  fetch must treat BTB lookups as misses while high.
- btb_wen  output  1  BTB write enable.
- btb_index  output  IDX_W  BTB write index.
- btb_wdat  output  32  BTB write data.

Behaviour:
- Reset nRST, asynchronous, active-low; clock CLK. All state on rising CLK edge.
- Reset values:
  - FIFO empty, state IDLE, sweep counter 1.
  - btb_wen=0, btb_index=0, btb_wdat=0.
  - flush_busy=0, flush_done=0, lookup_block=0.
  - upd_ready=1 once nRST deasserts.
- FIFO:
  - upd_ready = (state==IDLE) && !full.
  - On handshake with upd_index≠0, enqueue {index,target}.
  - On handshake with upd_index==0, accept and discard; no enqueue, no write.
  - Pointers IDX wrap modulo DEPTH; a separate count distinguishes full from empty.
  - Same-cycle enqueue and dequeue keeps count unchanged.
- State IDLE:
  - If FIFO not empty, drive btb_wen=1 with btb_index/btb_wdat from the head; dequeue at the edge (combinational from head).
  - Latency: an update accepted at edge N into an empty FIFO is written at edge N+1.
  - Writes retire in acceptance order; a later update to the same index overwrites an earlier one.
  - If flush_req=1, go to DRAIN at the next edge. A handshake in that same cycle is still accepted.
- State DRAIN:
  - upd_ready=0 and flush_busy=1.
  - Continue issuing head writes one per cycle.
  - When FIFO is empty, go to SWEEP, even if it was already empty on entry (DRAIN lasts ≥1 cycle).
- State SWEEP:
  - flush_busy=1, lookup_block=1, btb_wen=1, btb_index=counter, btb_wdat=0.
  - Counter increments from 1 to ENTRIES-1. Entry 0 is never written, and the counter never wraps to 0.
  - After writing ENTRIES-1, go to DONE and reload counter to 1.
  - Sweep lasts exactly ENTRIES-1 cycles (2047 at default).
- State DONE:
  - flush_done=1 for one cycle; flush_busy=0, lookup_block=0, btb_wen=0.
  - Return to IDLE unconditionally.
  - If flush_req is still high in IDLE, a new flush starts. The requester drops flush_req on flush_done.
- flush_req changes while in DRAIN, SWEEP or DONE are ignored.
- btb_wen=0 whenever no write is issued. btb_index/btb_wdat are then held at 0.
- Reset asserted mid-sweep or mid-drain: immediately return to reset values. Pending FIFO entries are lost, and the partially swept BTB is not completed.

Test Plan:
- Reset, then accept a single update (upd_index=0x12A, upd_target=0x0000_4000) → btb_wen=1, btb_index=0x12A, btb_wdat=0x0000_4000 exactly one cycle after the handshake, then btb_wen=0.
- Hold btb writes busy by offering 6 back-to-back updates (indices 1..6) → upd_ready high throughout (drain 1/cycle keeps FIFO ≤1). Writes appear in order 1..6 on consecutive cycles.
- Update with upd_index=0, target 0xDEAD_BEEF → handshake completes, btb_wen stays 0, FIFO count unchanged.
- Enqueue 3 updates, then assert flush_req the cycle after the third handshake:
  - upd_ready drops; the 3 queued writes issue first.
  - Then 2047 writes with btb_wdat=0 for indices 1..2047; lookup_block=1 during the sweep.
  - flush_done pulses one cycle, then upd_ready=1.
- Flush with an empty FIFO → one DRAIN cycle, then the sweep starts. Index 0 is never written, and index 2047 is the last write.
- Assert nRST at sweep index 500 → all outputs return to reset values asynchronously. After release, state is IDLE, upd_ready=1, and a fresh update writes normally.
